skew_drain: RTL and testbench

- Receives the TPU's diagonal-skewed result write stream: active-low write enable, word address, 8-lane wavefront data.
- Buffers one complete ARRAY_SIZE x ARRAY_SIZE result tile.
- On the TPU done pulse, de-skews the tile and streams it out one row per beat over a valid/ready interface.
- Sits between tpu_top's result-SRAM write port and the host-side output path; it consumes that write stream.

---
 rtl/skew_pkg.sv | 26 ++
 rtl/skew_row_mux.sv | 22 ++
 rtl/skew_drain.sv | 108 ++++++++++
 tb/tb_skew_drain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_pkg.sv
// Shared definitions for the skew drain block: array geometry, FSM state
// encoding and a lane-slice helper used wherever a wavefront word is picked
// apart.
package skew_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int W          = 16;
  localparam int ADDR_WIDTH = 6;
  localparam int NWORDS     = 2 * ARRAY_SIZE - 1;
  localparam int WORD_W     = ARRAY_SIZE * W;
  localparam int ROW_W      = $clog2(ARRAY_SIZE);
  localparam int IDX_W      = $clog2(NWORDS);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_e;

  // Lane 0 sits in the most significant slice of a word.
  function automatic logic [W-1:0] lane(input word_t word, input int idx);
    return word[(ARRAY_SIZE-idx)*W-1 -: W];
  endfunction

endpackage

// File: rtl/skew_row_mux.sv
// Combinational de-skew of one result row out of the wavefront buffer.
// Element C[r][j] lives in lane r of buffer word r+j.
//   buf_words : the NWORDS wavefront words
//   row_idx   : row r to extract
//   row       : de-skewed row, column 0 in the most significant slice
module skew_row_mux
  import skew_pkg::*;
(
  input  word_t            buf_words [NWORDS],
  input  logic [ROW_W-1:0] row_idx,
  output word_t            row
);

  always_comb begin
    row = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      row[(ARRAY_SIZE-j)*W-1 -: W] =
        lane(buf_words[IDX_W'(int'(row_idx) + j)], int'(row_idx));
    end
  end

endmodule

// File: rtl/skew_drain.sv
// Collects the TPU's diagonal-skewed result write stream into a wavefront
// buffer and, on tpu_done, drains the de-skewed tile one row per beat.
//   clock, reset          : system clock, synchronous active-high reset
//   wr_en_n, waddr, wdata : TPU result write port (active-low strobe)
//   tpu_done              : single-cycle tile-complete pulse
//   out_valid/out_ready   : row beat handshake
//   out_row, out_row_idx  : row data and its index
//   out_last              : marks the final row of the tile
//   busy                  : drain in progress
//   err                   : sticky protocol error (bad address, write or
//                           done while draining)
//
// state     | meaning
// S_COLLECT | accept wavefront writes, wait for tpu_done
// S_DRAIN   | present rows 0..ARRAY_SIZE-1, writes and done are errors
module skew_drain
  import skew_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en_n,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  tpu_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_row,
  output logic [ROW_W-1:0]      out_row_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_SIZE - 1);

  state_e           state_q, state_d;
  word_t            buf_q [NWORDS];
  word_t            buf_d [NWORDS];
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_COLLECT;
      row_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    valid_d = valid_q;
    err_d   = err_q;
    buf_d   = buf_q;
    case (state_q)
      S_COLLECT: begin
        if (!wr_en_n) begin
          if (waddr < ADDR_WIDTH'(NWORDS)) buf_d[waddr[IDX_W-1:0]] = wdata;
          else err_d = 1'b1;
        end
        // A write in the same cycle as done is already folded into buf_d.
        if (tpu_done) begin
          state_d = S_DRAIN;
          row_d   = '0;
          valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!wr_en_n || tpu_done) err_d = 1'b1;
        if (valid_q && out_ready) begin
          if (row_q == LAST_ROW) begin
            // Clearing here lets unwritten words of the next tile read as 0.
            for (int i = 0; i < NWORDS; i++) buf_d[i] = '0;
            valid_d = 1'b0;
            row_d   = '0;
            state_d = S_COLLECT;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  skew_row_mux u_row_mux (
    .buf_words (buf_q),
    .row_idx   (row_q),
    .row       (out_row)
  );

  assign out_valid   = valid_q;
  assign out_row_idx = row_q;
  assign out_last    = valid_q && (row_q == LAST_ROW);
  assign busy        = (state_q == S_DRAIN);
  assign err         = err_q;

endmodule

// File: tb/tb_skew_drain.sv
// Randomised scoreboard bench for skew_drain. The reference model keeps the
// tile as a plain element array; on tpu_done it snapshots the expected rows
// into a queue that a negedge monitor checks against every presented beat.
module tb_skew_drain;
  import skew_pkg::*;

  typedef struct {
    logic [WORD_W-1:0] row;
    logic [ROW_W-1:0]  idx;
    logic              last;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  wr_en_n = 1'b1;
  logic [ADDR_WIDTH-1:0] waddr = '0;
  logic [WORD_W-1:0]     wdata = '0;
  logic                  tpu_done = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [WORD_W-1:0]     out_row;
  logic [ROW_W-1:0]      out_row_idx;
  logic                  out_last;
  logic                  busy;
  logic                  err;

  skew_drain dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en_n     (wr_en_n),
    .waddr       (waddr),
    .wdata       (wdata),
    .tpu_done    (tpu_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .busy        (busy),
    .err         (err)
  );

  always #5 clock = ~clock;

  int   n_chk = 0;
  int   n_fail = 0;
  int   beats_seen = 0;
  exp_t exp_q[$];

  // Model: m_buf[k][r] is lane r of wavefront word k.
  logic [W-1:0] m_buf [NWORDS][ARRAY_SIZE];
  logic         err_exp = 1'b0;

  int         ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  logic [3:0] ready_pat = 4'b1001;
  int         pat_i = 0;

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_clear();
    for (int k = 0; k < NWORDS; k++)
      for (int r = 0; r < ARRAY_SIZE; r++) m_buf[k][r] = '0;
  endfunction

  function automatic void model_write(input int addr, input logic [WORD_W-1:0] data);
    if (exp_q.size() != 0 || addr >= NWORDS) begin
      err_exp = 1'b1;
    end else begin
      for (int r = 0; r < ARRAY_SIZE; r++) m_buf[addr][r] = data[(ARRAY_SIZE-r)*W-1 -: W];
    end
  endfunction

  // Snapshot the tile: row r column j is lane r of word r+j.
  function automatic void model_done();
    exp_t e;
    if (exp_q.size() != 0) begin
      err_exp = 1'b1;
      return;
    end
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      e.row = '0;
      for (int j = 0; j < ARRAY_SIZE; j++) e.row[(ARRAY_SIZE-j)*W-1 -: W] = m_buf[r+j][r];
      e.idx  = ROW_W'(r);
      e.last = (r == ARRAY_SIZE - 1);
      exp_q.push_back(e);
    end
    model_clear();
  endfunction

  task automatic do_write(input int addr, input logic [WORD_W-1:0] data);
    wr_en_n = 1'b0;
    waddr   = ADDR_WIDTH'(addr);
    wdata   = data;
    model_write(addr, data);
    tick();
    wr_en_n = 1'b1;
  endtask

  // Done pulse, optionally with a write in the same cycle.
  task automatic do_done(input bit with_wr, input int addr, input logic [WORD_W-1:0] data);
    if (with_wr) begin
      wr_en_n = 1'b0;
      waddr   = ADDR_WIDTH'(addr);
      wdata   = data;
      model_write(addr, data);
    end
    tpu_done = 1'b1;
    model_done();
    tick();
    tpu_done = 1'b0;
    wr_en_n  = 1'b1;
  endtask

  function automatic logic [WORD_W-1:0] pattern_word(input int k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int r = 0; r < ARRAY_SIZE; r++) w[(ARRAY_SIZE-r)*W-1 -: W] = W'(r * 16 + k);
    return w;
  endfunction

  task automatic fill_pattern(input int nwords);
    for (int k = 0; k < nwords; k++) do_write(k, pattern_word(k));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  task automatic rand_word(output logic [WORD_W-1:0] w);
    for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
  endtask

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = ready_pat[pat_i];
        pat_i = (pat_i + 1) % 4;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every presented beat against the queue head; pop on transfer.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got row_idx %0d expected no beat", out_row_idx);
      end else begin
        chk("row_data", out_row, exp_q[0].row);
        chk("row_idx", WORD_W'(out_row_idx), WORD_W'(exp_q[0].idx));
        chk("row_last", WORD_W'(out_last), WORD_W'(exp_q[0].last));
        chk("busy_in_drain", WORD_W'(busy), 1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WORD_W-1:0] w;
    int n;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_out_valid", WORD_W'(out_valid), 0);
    chk("rst_busy", WORD_W'(busy), 0);
    chk("rst_err", WORD_W'(err), 0);
    chk("rst_out_last", WORD_W'(out_last), 0);
    chk("rst_row_idx", WORD_W'(out_row_idx), 0);
    chk("rst_out_row", out_row, 0);

    // Full pattern fill, continuous ready: first beat one cycle after done, 8 cycles of drain.
    fill_pattern(NWORDS);
    chk("valid_before_done", WORD_W'(out_valid), 0);
    do_done(0, 0, '0);
    chk("valid_after_done", WORD_W'(out_valid), 1);
    chk("busy_after_done", WORD_W'(busy), 1);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_cycles", WORD_W'(n), ARRAY_SIZE);
    wait_drain();
    chk("err_clean", WORD_W'(err), 0);

    // Same fill with stalls.
    ready_mode = 1;
    pat_i = 0;
    beats_seen = 0;
    fill_pattern(NWORDS);
    do_done(0, 0, '0);
    wait_drain();
    chk("stall_beats", WORD_W'(beats_seen), ARRAY_SIZE);
    ready_mode = 0;
    tick();

    // Out-of-range writes flag err; the tile itself is unaffected.
    do_write(15, '1);
    do_write(63, '1);
    chk("err_bad_addr", WORD_W'(err), WORD_W'(err_exp));
    fill_pattern(NWORDS);
    do_done(0, 0, '0);
    do_write(3, '1);
    wait_drain();
    chk("err_sticky", WORD_W'(err), WORD_W'(err_exp));

    // Last word lands in the same cycle as done.
    fill_pattern(NWORDS - 1);
    do_done(1, NWORDS - 1, pattern_word(NWORDS - 1) ^ {W'(16'hA5A5), {(WORD_W-W){1'b0}}} ^ W'(16'h1234));
    wait_drain();

    // Partial tile after a full one: upper words must read as zero.
    fill_pattern(NWORDS);
    do_done(0, 0, '0);
    wait_drain();
    fill_pattern(8);
    do_done(0, 0, '0);
    wait_drain();

    // Reset in the middle of a drain.
    fill_pattern(NWORDS);
    beats_seen = 0;
    do_done(0, 0, '0);
    n = 0;
    while (beats_seen < 3 && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    err_exp = 1'b0;
    chk("midrst_valid", WORD_W'(out_valid), 0);
    chk("midrst_busy", WORD_W'(busy), 0);
    chk("midrst_err", WORD_W'(err), 0);
    fill_pattern(NWORDS);
    do_done(0, 0, '0);
    chk("postrst_idx", WORD_W'(out_row_idx), 0);
    do_done(0, 0, '0);
    chk("err_done_in_drain", WORD_W'(err), WORD_W'(err_exp));
    wait_drain();

    // Random tiles with random backpressure.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 20; i++) begin
        rand_word(w);
        if ($urandom_range(0, 9) == 0) do_write($urandom_range(NWORDS, 63), w);
        else do_write($urandom_range(0, NWORDS - 1), w);
      end
      rand_word(w);
      do_done(($urandom_range(0, 1) == 1), $urandom_range(0, NWORDS - 1), w);
      if ($urandom_range(0, 3) == 0) begin
        rand_word(w);
        do_write($urandom_range(0, NWORDS - 1), w);
      end
      wait_drain();
      chk("rand_err", WORD_W'(err), WORD_W'(err_exp));
    end
    ready_mode = 0;
    repeat (3) tick();
    chk("final_idle", WORD_W'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
